// File: rtl/icache_param.sv
// icache_param: direct-mapped instruction cache with parameterised geometry.
//
// Ports:
//   CLK, RST             rising-edge clock, asynchronous active-high reset
//   imemREN, imemaddr    datapath fetch request and byte address (bits [1:0] ignored)
//   halt                 datapath halted; no new fills start
//   iflush               invalidate every line (aborts an in-progress fill)
//   ihit, imemload       fetched word valid this cycle, and the word itself
//   iREN, iaddr          memory read request and word-aligned address
//   iload, iwait         memory read data, memory busy
//   hit_count            saturating count of cycles with ihit=1
//   miss_count           saturating count of fills started
module icache_param #(
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [31:0]        hit_count_q, hit_count_d;
    logic [31:0]        miss_count_q, miss_count_d;

    // Tag and data arrays carry no reset; valid_q alone decides whether a line is usable.
    logic [TAG_W-1:0]            tag_q  [SETS];
    logic [BLOCK_WORDS*32-1:0]   data_q [SETS];

    logic [CNT_W-1:0]          req_off;
    logic [IDX_W-1:0]          req_idx;
    logic [TAG_W-1:0]          req_tag;
    logic [BLOCK_WORDS*32-1:0] hit_line;
    logic [31:0]               fill_base;
    logic                      fill_we;
    logic                      line_done;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^imemaddr[1:0];

    // Address split on the word address: offset | index | tag, low to high.
    always_comb begin
        req_off = (OFF_W == 0) ? '0 : CNT_W'(imemaddr[31:2]);
        req_idx = IDX_W'(imemaddr[31:2] >> OFF_W);
        req_tag = TAG_W'(imemaddr[31:2] >> (OFF_W + IDX_W));
    end

    // Hit path is purely combinational; a same-cycle flush suppresses it.
    always_comb begin
        hit_line = data_q[req_idx];
        ihit     = (state_q == StIdle) && imemREN && !iflush && valid_q[req_idx]
                   && (tag_q[req_idx] == req_tag);
        imemload = ihit ? hit_line[32*req_off +: 32] : '0;
    end

    assign fill_base = 32'({miss_tag_q, miss_idx_q}) << (OFF_W + 2);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        fill_we      = 1'b0;
        line_done    = 1'b0;
        iREN         = 1'b0;
        iaddr        = '0;

        if (ihit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end

        case (state_q)
            StIdle: begin
                if (iflush) begin
                    valid_d = '0;
                end else if (imemREN && !ihit && !halt) begin
                    state_d    = StFill;
                    cnt_d      = '0;
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end
                end
            end
            StFill: begin
                iREN  = 1'b1;
                iaddr = fill_base | (32'(cnt_q) << 2);
                if (iflush) begin
                    // Abort: the partially written line was never marked valid.
                    valid_d = '0;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (!iwait) begin
                    fill_we = 1'b1;
                    if (cnt_q == CntLast) begin
                        line_done           = 1'b1;
                        valid_d[miss_idx_q] = 1'b1;
                        state_d             = StIdle;
                        cnt_d               = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_tag_q   <= miss_tag_d;
            miss_idx_q   <= miss_idx_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_q[miss_idx_q][32*cnt_q +: 32] <= iload;
        end
        if (line_done) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param (SETS=16, BLOCK_WORDS=2).
// Memory returns word(a) = a; iwait is held high wait_lat cycles before each word.
module tb_icache_param;

    localparam int unsigned SETS = 16;
    localparam int unsigned BW   = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        halt;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_param #(
        .SETS        (SETS),
        .BLOCK_WORDS (BW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .halt       (halt),
        .iflush     (iflush),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iload      (iload),
        .iwait      (iwait),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    int unsigned wait_lat;
    int unsigned wait_cnt;

    assign iload = iaddr;
    assign iwait = iREN && (wait_cnt < wait_lat);

    always @(posedge CLK or posedge RST) begin
        if (RST) wait_cnt <= 0;
        else if (iREN && iwait) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int n_checks;
    int n_pass;

    // Reference model: which line each set holds, plus expected counter values.
    bit          mvalid [SETS];
    int unsigned mtag   [SETS];
    int unsigned exp_hits;
    int unsigned exp_misses;
    logic [31:0] aq [$];

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a / 4 / BW) % SETS;
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] a);
        return a / 4 / BW / SETS;
    endfunction

    function automatic bit m_present(input logic [31:0] a);
        return mvalid[m_idx(a)] && (mtag[m_idx(a)] == m_tag(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    endtask

    // Holds a fetch until ihit; returns observed and model-predicted stall cycles.
    // Starts and ends just after a falling edge.
    task automatic run_fetch(input logic [31:0] a, input int unsigned w, input bit raise_halt,
                             output int lat, output logic [31:0] d, output bit ok,
                             output int exp_lat);
        bit pres;
        pres    = m_present(a);
        exp_lat = pres ? 0 : int'(BW * (w + 1) + 1);
        wait_lat = w;
        imemREN  = 1'b1;
        imemaddr = a;
        lat = 0;
        ok  = 1'b0;
        d   = '0;
        aq.delete();
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ihit === 1'b1) begin
                d  = imemload;
                ok = 1'b1;
                break;
            end
            if (iREN === 1'b1) aq.push_back(iaddr);
            lat++;
            @(negedge CLK);
            if (raise_halt) halt = 1'b1;
        end
        if (ok) @(negedge CLK);
        imemREN = 1'b0;
        halt    = 1'b0;
        if (!pres) begin
            mvalid[m_idx(a)] = 1'b1;
            mtag[m_idx(a)]   = m_tag(a);
            exp_misses++;
        end
        if (ok) exp_hits++;
    endtask

    task automatic test_reset();
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; halt = 1'b0; iflush = 1'b0; wait_lat = 0;
        model_clear(); exp_hits = 0; exp_misses = 0;
        @(negedge CLK); @(negedge CLK);
        #1;
        n_checks++;
        if ({ihit, iREN, iaddr, imemload} !== '0) $display("FAIL reset_outputs: got ihit=%b iREN=%b iaddr=%h imemload=%h, want all 0", ihit, iREN, iaddr, imemload);
        else n_pass++;
        n_checks++;
        if (hit_count !== 0 || miss_count !== 0) $display("FAIL reset_counters: got %0d/%0d, want 0/0", hit_count, miss_count);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_cold_miss();
        int lat; int el; logic [31:0] d; bit ok;
        run_fetch(32'h40, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || lat != el) $display("FAIL cold_miss_latency: got %0d (ok=%b), want 3", lat, ok);
        else n_pass++;
        n_checks++;
        if (d !== 32'h40) $display("FAIL cold_miss_data: got %h, want 00000040", d);
        else n_pass++;
        n_checks++;
        if (aq.size() != 2 || aq[0] !== 32'h40 || aq[1] !== 32'h44) $display("FAIL cold_miss_iaddr: got %p, want 40,44", aq);
        else n_pass++;
        n_checks++;
        if (miss_count !== 1 || hit_count !== exp_hits) $display("FAIL cold_miss_counts: got miss=%0d hit=%0d, want 1/%0d", miss_count, hit_count, exp_hits);
        else n_pass++;
    endtask

    task automatic test_same_line_hit();
        imemREN = 1'b1; imemaddr = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ihit !== 1'b1 || imemload !== 32'h44) $display("FAIL same_line_hit[%0d]: got ihit=%b data=%h, want 1/00000044", i, ihit, imemload);
            else n_pass++;
            @(negedge CLK);
        end
        imemREN = 1'b0;
        exp_hits += 3;
        n_checks++;
        if (hit_count !== exp_hits) $display("FAIL same_line_hit_count: got %0d, want %0d", hit_count, exp_hits);
        else n_pass++;
    endtask

    task automatic test_conflict();
        int lat; int el; logic [31:0] d; bit ok;
        run_fetch(32'h840, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != el || d !== 32'h840) $display("FAIL conflict_fill: got lat=%0d data=%h, want %0d/00000840", lat, d, el);
        else n_pass++;
        run_fetch(32'h40, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || d !== 32'h40) $display("FAIL conflict_refetch: got lat=%0d data=%h, want 3/00000040", lat, d);
        else n_pass++;
        n_checks++;
        if (miss_count !== 3) $display("FAIL conflict_misses: got %0d, want 3", miss_count);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        int lat; int el; logic [31:0] d; bit ok;
        run_fetch(32'h100, 2, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 7 || d !== 32'h100) $display("FAIL wait_latency: got lat=%0d data=%h, want 7/00000100", lat, d);
        else n_pass++;
        n_checks++;
        if (aq.size() != 6 || aq[0] !== 32'h100 || aq[2] !== 32'h100 || aq[3] !== 32'h104 || aq[5] !== 32'h104)
            $display("FAIL wait_iaddr_hold: got %p, want 100x3,104x3", aq);
        else n_pass++;
    endtask

    task automatic test_flush();
        int lat; int el; logic [31:0] d; bit ok;
        run_fetch(32'h40, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 0) $display("FAIL flush_prehit: got lat=%0d, want 0", lat);
        else n_pass++;
        imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b1;
        #1;
        n_checks++;
        if (ihit !== 1'b0) $display("FAIL flush_same_cycle_ihit: got %b, want 0", ihit);
        else n_pass++;
        @(negedge CLK);
        iflush = 1'b0; imemREN = 1'b0;
        model_clear();
        run_fetch(32'h40, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || d !== 32'h40) $display("FAIL flush_refetch: got lat=%0d data=%h, want 3/00000040", lat, d);
        else n_pass++;
        // Flush while a fill is stalled on iwait.
        wait_lat = 3; imemREN = 1'b1; imemaddr = 32'h80;
        @(negedge CLK);
        exp_misses++;
        #1;
        n_checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h80) $display("FAIL flush_fill_started: got iREN=%b iaddr=%h, want 1/00000080", iREN, iaddr);
        else n_pass++;
        imemREN = 1'b0; iflush = 1'b1;
        @(negedge CLK);
        iflush = 1'b0;
        #1;
        n_checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0) $display("FAIL flush_abort: got iREN=%b ihit=%b, want 0/0", iREN, ihit);
        else n_pass++;
        @(negedge CLK);
        model_clear();
        run_fetch(32'h80, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || d !== 32'h80) $display("FAIL flush_abort_line_invalid: got lat=%0d data=%h, want 3/00000080", lat, d);
        else n_pass++;
        n_checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) $display("FAIL flush_counts: got %0d/%0d, want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
        else n_pass++;
    endtask

    task automatic test_halt();
        int lat; int el; logic [31:0] d; bit ok;
        halt = 1'b1; imemREN = 1'b1; imemaddr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (iREN !== 1'b0 || ihit !== 1'b0) $display("FAIL halt_blocks_fill[%0d]: got iREN=%b ihit=%b, want 0/0", i, iREN, ihit);
            else n_pass++;
            @(negedge CLK);
        end
        imemREN = 1'b0;
        n_checks++;
        if (miss_count !== exp_misses) $display("FAIL halt_misses: got %0d, want %0d", miss_count, exp_misses);
        else n_pass++;
        run_fetch(32'h84, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 0 || d !== 32'h84) $display("FAIL halt_hit_served: got lat=%0d data=%h, want 0/00000084", lat, d);
        else n_pass++;
        run_fetch(32'h300, 0, 1'b1, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || d !== 32'h300) $display("FAIL halt_mid_fill: got lat=%0d data=%h, want 3/00000300", lat, d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int lat; int el; logic [31:0] d; bit ok;
        wait_lat = 3; imemREN = 1'b1; imemaddr = 32'h400;
        @(negedge CLK);
        #1;
        n_checks++;
        if (iREN !== 1'b1) $display("FAIL rst_fill_started: got iREN=%b, want 1", iREN);
        else n_pass++;
        RST = 1'b1;
        #1;
        n_checks++;
        if (iREN !== 1'b0 || iaddr !== 0 || hit_count !== 0 || miss_count !== 0)
            $display("FAIL rst_immediate: got iREN=%b iaddr=%h hit=%0d miss=%0d, want 0", iREN, iaddr, hit_count, miss_count);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b0; imemREN = 1'b0;
        model_clear(); exp_hits = 0; exp_misses = 0;
        run_fetch(32'h400, 0, 1'b0, lat, d, ok, el);
        n_checks++;
        if (!ok || lat != 3 || d !== 32'h400 || miss_count !== 1) $display("FAIL rst_refetch: got lat=%0d data=%h miss=%0d, want 3/00000400/1", lat, d, miss_count);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; int el; logic [31:0] d; bit ok;
        logic [31:0] a;
        int errs;
        errs = 0;
        for (int it = 0; it < 200; it++) begin
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 3)
                | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0: begin
                    iflush = 1'b1; imemREN = 1'($urandom_range(0, 1)); imemaddr = a;
                    #1;
                    n_checks++;
                    if (ihit !== 1'b0) begin $display("FAIL rand_flush_ihit[%0d]: got %b, want 0", it, ihit); errs++; end
                    else n_pass++;
                    @(negedge CLK);
                    iflush = 1'b0; imemREN = 1'b0;
                    model_clear();
                end
                1: begin
                    halt = 1'b1; imemREN = 1'b1; imemaddr = a;
                    #1;
                    n_checks++;
                    if (ihit !== m_present(a) || (m_present(a) && imemload !== {a[31:2], 2'b00}))
                        begin $display("FAIL rand_halt[%0d]: got ihit=%b data=%h addr=%h", it, ihit, imemload, a); errs++; end
                    else n_pass++;
                    if (m_present(a)) exp_hits++;
                    @(negedge CLK);
                    halt = 1'b0; imemREN = 1'b0;
                end
                default: begin
                    run_fetch(a, $urandom_range(0, 2), 1'b0, lat, d, ok, el);
                    n_checks++;
                    if (!ok || lat != el || d !== {a[31:2], 2'b00})
                        begin $display("FAIL rand_fetch[%0d]: addr=%h got lat=%0d data=%h, want %0d/%h", it, a, lat, d, el, {a[31:2], 2'b00}); errs++; end
                    else n_pass++;
                end
            endcase
            if (errs > 10) break;
        end
        n_checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses)
            $display("FAIL rand_counters: got %0d/%0d, want %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_cold_miss();
        test_same_line_hit();
        test_conflict();
        test_wait_states();
        test_flush();
        test_halt();
        test_reset_mid_fill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_param.md
ICACHE_PARAM -- requirements
Module: icache_param

Interface
REQ-001 Parameter SETS, default 16: number of direct-mapped lines; power of two, 2..256.
REQ-002 Parameter BLOCK_WORDS, default 2: 32-bit words per line; power of two, 1..8.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 imemREN  in  1  datapath fetch request.
REQ-007 imemaddr  in  32  datapath byte address; bits[1:0] ignored.
REQ-008 halt  in  1  datapath halted; blocks new fills.
REQ-009 iflush  in  1  invalidate all lines.
REQ-010 ihit  out  1  imemload valid this cycle.
REQ-011 imemload  out  32  fetched instruction.
REQ-012 iREN  out  1  memory read request.
REQ-013 iaddr  out  32  memory word address, bits[1:0]=00.
REQ-014 iload  in  32  memory read data.
REQ-015 iwait  in  1  memory busy; iload valid when iREN=1 and iwait=0.
REQ-016 hit_count  out  32  hits since reset, saturating.
REQ-017 miss_count  out  32  misses since reset, saturating.

Function
REQ-018 Address split: offset = bits[2 +: log2(BLOCK_WORDS)]; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-019 Storage per line: valid bit, tag, BLOCK_WORDS data words.
REQ-020 FSM states IDLE and FILL; word counter cnt, width max(1, log2(BLOCK_WORDS)).
REQ-021 Hit, combinational, IDLE only: ihit = imemREN & valid[index] & tag match; imemload = stored word at offset; zero-cycle latency.
REQ-022 ihit=0 in FILL and whenever imemREN=0; imemload=0 when ihit=0.
REQ-023 Miss in IDLE (imemREN, no hit, halt=0, iflush=0): next state FILL, cnt=0, latch miss tag and index, miss_count+1.
REQ-024 FILL: iREN=1; iaddr = {miss tag, miss index, cnt, 2'b00}.
REQ-025 FILL with iwait=0: write iload into word cnt; cnt+1.
REQ-026 FILL with iwait=0 and cnt=BLOCK_WORDS-1: set valid, write tag, return to IDLE; requested word hits the following cycle.
REQ-027 Miss penalty: ihit low for BLOCK_WORDS*(W+1)+1 cycles, where W = iwait-high cycles per word.
REQ-028 IDLE: iREN=0, iaddr=0.
REQ-029 imemREN or imemaddr change during FILL: ignored; fill completes.
REQ-030 halt=1 in IDLE: no fill starts; hits still served; halt during FILL: fill completes.
REQ-031 iflush=1 in IDLE: all valid bits cleared at next edge; ihit=0 that cycle.
REQ-032 iflush=1 in FILL: fill aborted, state IDLE, all valid bits cleared; partially written line stays invalid.
REQ-033 hit_count increments on every cycle with ihit=1; counters saturate at 0xFFFFFFFF, no wrap.

Reset
REQ-034 RST=1, immediate and regardless of CLK: state IDLE, cnt=0, all valid=0, hit_count=0, miss_count=0; ihit, iREN, iaddr, imemload = 0.
REQ-035 RST mid-FILL: fill abandoned, line stays invalid; first fetch after release misses.
REQ-036 Data and tag arrays need no reset; valid bits alone gate hits.

Verification (SETS=16, BLOCK_WORDS=2)
REQ-037 Cold miss: reset, imemREN=1, imemaddr=0x40, iwait=0, memory word(a)=a -> iaddr 0x40 then 0x44; ihit=1 on cycle 3 with imemload=0x40; miss_count=1.
REQ-038 Same-line hit: then imemaddr=0x44 -> ihit=1 same cycle, imemload=0x44; hit_count increments each cycle held.
REQ-039 Conflict eviction: read 0x840 (same index 8, new tag) -> miss, refill 0x840/0x844; re-read 0x40 -> miss again; miss_count=3.
REQ-040 Wait states: iwait high 2 cycles before each word, read 0x100 -> ihit low for 7 cycles; iaddr holds each address while iwait=1.
REQ-041 Flush: fill 0x40, pulse iflush one cycle, re-read 0x40 -> miss; iflush mid-FILL -> IDLE next cycle, iREN=0, line invalid.
REQ-042 Halt/reset: halt=1 with miss at 0x200 -> iREN stays 0, ihit=0, miss_count unchanged; RST during FILL -> iREN=0 immediately, counters 0.
